// File: rtl/lsu_pkg.sv
// lsu_pkg
// Shared definitions for the load/store unit.
// The package contains:
//   - the funct3 encodings for loads and stores,
//   - the FSM state enum,
//   - the access-size encoding,
//   - a helper that decides whether a funct3 is legal for a given direction.
package lsu_pkg;

   // Load funct3 encodings (RISC-V).
   localparam logic [2:0] LF3_LB  = 3'b000;
   localparam logic [2:0] LF3_LH  = 3'b001;
   localparam logic [2:0] LF3_LW  = 3'b010;
   localparam logic [2:0] LF3_LBU = 3'b100;
   localparam logic [2:0] LF3_LHU = 3'b101;

   // Store funct3 encodings (RISC-V).
   localparam logic [2:0] SF3_SB  = 3'b000;
   localparam logic [2:0] SF3_SH  = 3'b001;
   localparam logic [2:0] SF3_SW  = 3'b010;

   typedef enum logic [2:0] {
      IDLE,
      REQ0,
      WAIT0,
      REQ1,
      WAIT1,
      RESP
   } lsu_state_t;

   // Access size is carried in funct3[1:0].
   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10
   } lsu_size_t;

   // Loads accept the signed and unsigned variants.
   // Stores only accept the three plain sizes.
   function automatic logic f3_valid(input logic we, input logic [2:0] f3);
      if (we) begin
         return (f3 == SF3_SB) || (f3 == SF3_SH) || (f3 == SF3_SW);
      end
      return (f3 == LF3_LB) || (f3 == LF3_LH) || (f3 == LF3_LW) ||
             (f3 == LF3_LBU) || (f3 == LF3_LHU);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align
// Purely combinational lane logic for the load/store unit.
// It turns a byte offset and a size into the following:
//   - byte enables for up to two word accesses,
//   - the lane-shifted store data,
//   - the split decision,
//   - the extended load result taken from the two captured read words.
// Ports:
//   off        byte offset within the word (addr[1:0])
//   f3         funct3 (size in [1:0], unsigned flag in [2])
//   wdata      right-justified store data
//   rdata0/1   read data of access 0 / access 1
//   split      access straddles a word boundary
//   be0/be1    byte enables for access 0 / access 1
//   wdata0/1   lane-aligned write data for access 0 / access 1
//   load_data  shifted and sign/zero-extended load value
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  off,
   input  logic [2:0]  f3,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata0,
   input  logic [31:0] rdata1,
   output logic        split,
   output logic [3:0]  be0,
   output logic [3:0]  be1,
   output logic [31:0] wdata0,
   output logic [31:0] wdata1,
   output logic [31:0] load_data
);

   logic [7:0]  size_mask;
   logic [7:0]  be_mask;
   logic [5:0]  bit_off;
   logic [63:0] wdata_shift;
   logic [31:0] rdata_word;

   assign bit_off = {1'b0, off, 3'b000};

   // Size mask before shifting.
   // The mask is 8 bits wide so that any bytes which spill into the next word
   // land in the upper nibble.
   always_comb begin
      size_mask = 8'h01;
      if (f3[1:0] == SIZE_HALF) begin
         size_mask = 8'h03;
      end else if (f3[1:0] == SIZE_WORD) begin
         size_mask = 8'h0F;
      end
   end

   assign be_mask = size_mask << off;
   assign be0     = be_mask[3:0];
   assign be1     = be_mask[7:4];
   assign split   = ((f3[1:0] == SIZE_WORD) && (off != 2'd0)) ||
                    ((f3[1:0] == SIZE_HALF) && (off == 2'd3));

   assign wdata_shift = {32'b0, wdata} << bit_off;
   assign wdata0      = wdata_shift[31:0];
   assign wdata1      = wdata_shift[63:32];

   // The two read words are concatenated so that a straddling access becomes
   // one contiguous value before the extension step.
   assign rdata_word = 32'({rdata1, rdata0} >> bit_off);

   // Sign- or zero-extend the load result according to funct3.
   always_comb begin
      load_data = rdata_word;
      case (f3)
         LF3_LB:  load_data = {{24{rdata_word[7]}}, rdata_word[7:0]};
         LF3_LH:  load_data = {{16{rdata_word[15]}}, rdata_word[15:0]};
         LF3_LBU: load_data = {24'b0, rdata_word[7:0]};
         LF3_LHU: load_data = {16'b0, rdata_word[15:0]};
         default: load_data = rdata_word;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit
// MEM-stage initiator for a handshaked, word-wide data bus.
// Behaviour:
//   - Accepts one load or store at a time.
//   - Splits misaligned accesses into two word transactions.
//   - Returns extended load data, or a store acknowledge.
//   - Reports an error for an illegal funct3 or for a bus timeout.
// Ports:
//   clk, reset                    clock; asynchronous active-high reset
//   req_valid/req_ready           pipeline request handshake
//   req_we, req_f3                direction and funct3
//   req_addr, req_wdata           byte address and store data
//   resp_valid/rdata/err          one-cycle completion pulse with result
//   busy                          stall to the pipeline (not IDLE)
//   bus_req/we/addr/be/wdata      registered bus request
//   bus_gnt, bus_rvalid, bus_rdata  bus grant, completion and read data
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MAX_WAIT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_f3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        busy,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_gnt,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   lsu_state_t       state;
   lsu_state_t       next_state;
   logic             we_q;
   logic [2:0]       f3_q;
   logic [31:0]      addr_q;
   logic [31:0]      wdata_q;
   logic [31:0]      rdata0_q;
   logic [31:0]      rdata1_q;
   logic [CNT_W-1:0] wait_cnt;
   logic             timeout;
   logic             in_idle;
   logic             resp_err_d;

   logic [1:0]  al_off;
   logic [2:0]  al_f3;
   logic [31:0] al_wdata;
   logic [31:0] al_rdata0;
   logic [31:0] al_rdata1;
   logic        split;
   logic [3:0]  be0;
   logic [3:0]  be1;
   logic [31:0] wdata0;
   logic [31:0] wdata1;
   logic [31:0] load_data;
   logic [29:0] word1;

   assign in_idle   = (state == IDLE);
   assign req_ready = in_idle;
   assign busy      = !in_idle;

   // In IDLE the aligner looks at the live request.
   // This lets the first bus access be registered on the accepting edge.
   // In every other state it works from the captured copy.
   assign al_off    = in_idle ? req_addr[1:0] : addr_q[1:0];
   assign al_f3     = in_idle ? req_f3        : f3_q;
   assign al_wdata  = in_idle ? req_wdata     : wdata_q;

   // The word that arrives on the completing edge is fed straight in.
   // This makes the load result ready to register together with resp_valid.
   assign al_rdata0 = (state == WAIT0) ? bus_rdata : rdata0_q;
   assign al_rdata1 = (state == WAIT1) ? bus_rdata : rdata1_q;

   assign word1   = addr_q[31:2] + 30'd1;
   assign timeout = !bus_rvalid && (wait_cnt == CNT_W'(MAX_WAIT - 1));

   // Only the IDLE path (illegal funct3) and the timeout path reach RESP
   // without a bus_rvalid.
   assign resp_err_d = in_idle || !bus_rvalid;

   lsu_align u_align (
      .off       (al_off),
      .f3        (al_f3),
      .wdata     (al_wdata),
      .rdata0    (al_rdata0),
      .rdata1    (al_rdata1),
      .split     (split),
      .be0       (be0),
      .be1       (be1),
      .wdata0    (wdata0),
      .wdata1    (wdata1),
      .load_data (load_data)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode.
   // A timeout in WAIT0 goes straight to RESP, so a pending second access is
   // never issued.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               next_state = f3_valid(req_we, req_f3) ? REQ0 : RESP;
            end
         end
         REQ0: begin
            if (bus_gnt) begin
               next_state = WAIT0;
            end
         end
         WAIT0: begin
            if (bus_rvalid) begin
               next_state = split ? REQ1 : RESP;
            end else if (timeout) begin
               next_state = RESP;
            end
         end
         REQ1: begin
            if (bus_gnt) begin
               next_state = WAIT1;
            end
         end
         WAIT1: begin
            if (bus_rvalid || timeout) begin
               next_state = RESP;
            end
         end
         RESP: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Datapath registers.
   // This block holds the request capture, the registered bus signals, the
   // read-data latches, the wait counter and the registered response.
   // Bus signals are loaded on the edge that enters a REQ state, so they are
   // stable for the whole time that state is held.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we_q       <= 1'b0;
         f3_q       <= 3'b000;
         addr_q     <= 32'b0;
         wdata_q    <= 32'b0;
         rdata0_q   <= 32'b0;
         rdata1_q   <= 32'b0;
         wait_cnt   <= '0;
         bus_req    <= 1'b0;
         bus_we     <= 1'b0;
         bus_addr   <= 32'b0;
         bus_be     <= 4'b0;
         bus_wdata  <= 32'b0;
         resp_valid <= 1'b0;
         resp_rdata <= 32'b0;
         resp_err   <= 1'b0;
      end else begin
         resp_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (req_valid) begin
                  we_q     <= req_we;
                  f3_q     <= req_f3;
                  addr_q   <= req_addr;
                  wdata_q  <= req_wdata;
                  rdata0_q <= 32'b0;
                  rdata1_q <= 32'b0;
                  if (next_state == REQ0) begin
                     bus_req   <= 1'b1;
                     bus_we    <= req_we;
                     bus_addr  <= {req_addr[31:2], 2'b00};
                     bus_be    <= be0;
                     bus_wdata <= wdata0;
                  end
               end
            end
            REQ0, REQ1: begin
               if (bus_gnt) begin
                  bus_req  <= 1'b0;
                  wait_cnt <= '0;
               end
            end
            WAIT0: begin
               if (bus_rvalid) begin
                  rdata0_q <= bus_rdata;
                  if (split) begin
                     bus_req   <= 1'b1;
                     bus_addr  <= {word1, 2'b00};
                     bus_be    <= be1;
                     bus_wdata <= wdata1;
                  end
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            WAIT1: begin
               if (bus_rvalid) begin
                  rdata1_q <= bus_rdata;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            default: begin
            end
         endcase

         // Response registered on the edge that enters RESP.
         // It is held until the next completion.
         if ((next_state == RESP) && (state != RESP)) begin
            resp_valid <= 1'b1;
            resp_err   <= resp_err_d;
            resp_rdata <= (resp_err_d || we_q) ? 32'b0 : load_data;
         end
      end
   end

endmodule
